piezo_sound_arbiter: RTL

Owns the single PIEZO output and shares it between the vehicle's audible sources: horn, hazard/ESS alert, turn-signal click, reverse beep and engine tone. It applies fixed priority, enforces a minimum hold time so that tones never chatter, and generates each source's square wave. It sits beside the vehicle logic and turn-signal blocks in the top level, and it replaces direct piezo driving by the sound unit.

---
 rtl/piezo_sound_arbiter_pkg.sv | 39 +++
 rtl/piezo_tone_gen.sv | 42 ++++
 rtl/piezo_sound_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/piezo_sound_arbiter_pkg.sv
// Purpose: shared source indices, arbiter states, default tone constants and the priority encoder.
// Latency: n/a (declarations and a pure combinational helper).
// Backpressure: n/a.
package piezo_sound_arbiter_pkg;

  // Bit positions inside the one-hot grant / request vectors
  localparam int SRC_HORN  = 4;
  localparam int SRC_ALERT = 3;
  localparam int SRC_CLICK = 2;
  localparam int SRC_REV   = 1;
  localparam int SRC_ENG   = 0;
  localparam int NUM_SRC   = 5;

  // Default half-periods in clocks at 50 MHz
  localparam int DEF_HORN_HALF     = 56818;
  localparam int DEF_ALERT_HALF    = 25000;
  localparam int DEF_REV_HALF      = 31250;
  localparam int DEF_CLICK_HALF    = 12500;
  localparam int DEF_ENG_BASE_HALF = 100000;
  localparam int DEF_ENG_MIN_HALF  = 20000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } arb_state_t;

  // Fixed priority, horn highest; returns one-hot winner or zero
  function automatic logic [NUM_SRC-1:0] prio_pick(input logic [NUM_SRC-1:0] req);
    logic [NUM_SRC-1:0] win;
    win = '0;
    if (req[SRC_HORN])       win[SRC_HORN]  = 1'b1;
    else if (req[SRC_ALERT]) win[SRC_ALERT] = 1'b1;
    else if (req[SRC_CLICK]) win[SRC_CLICK] = 1'b1;
    else if (req[SRC_REV])   win[SRC_REV]   = 1'b1;
    else if (req[SRC_ENG])   win[SRC_ENG]   = 1'b1;
    return win;
  endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Purpose: square-wave generator with restart/enable; half-period captured at each toggle.
// Latency: registered output; first toggle 'half' clocks after restart.
// Backpressure: none (free-running while enabled).
// Ports: clk, rst_n (sync, active-low), restart (phase to 0, output low), enable (low holds
//        phase reset), half[17:0] (half-period in clocks), wave (square-wave output).
module piezo_tone_gen
  import piezo_sound_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        enable,
  input  logic [17:0] half,
  output logic        wave
);

  logic [17:0] cnt;
  logic [17:0] half_q;
  logic        at_last;

  // Compare one wider so a zero half cannot wrap into a huge terminal count
  assign at_last = ({1'b0, cnt} + 19'd1) >= {1'b0, half_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      half_q <= '0;
      wave   <= 1'b0;
    end else if (restart || !enable) begin
      cnt    <= '0;
      half_q <= half;
      wave   <= 1'b0;
    end else if (at_last) begin
      cnt    <= '0;
      half_q <= half;
      wave   <= ~wave;
    end else begin
      cnt    <= cnt + 18'd1;
    end
  end

endmodule

// File: rtl/piezo_sound_arbiter.sv
// Purpose: shares the piezo between horn/alert/click/reverse/engine with priority and min hold.
// Latency: grant registered one clock after the winning request; piezo follows the grant.
// Backpressure: losing level requests simply wait; only turn clicks are latched.
// Ports: clk, rst_n (sync, active-low), engine_on, rpm[13:0], req_horn, req_alert, req_reverse,
//        turn_edge (pulse), piezo_out (square wave), grant[4:0] (one-hot), active (grant != 0).
module piezo_sound_arbiter
  import piezo_sound_arbiter_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int MIN_HOLD_MS   = 100,
  parameter int HORN_HALF     = DEF_HORN_HALF,
  parameter int ALERT_HALF    = DEF_ALERT_HALF,
  parameter int REV_HALF      = DEF_REV_HALF,
  parameter int CLICK_HALF    = DEF_CLICK_HALF,
  parameter int TURN_CLICK_MS = 5,
  parameter int REV_ON_MS     = 300,
  parameter int ENG_BASE_HALF = DEF_ENG_BASE_HALF,
  parameter int ENG_MIN_HALF  = DEF_ENG_MIN_HALF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        engine_on,
  input  logic [13:0] rpm,
  input  logic        req_horn,
  input  logic        req_alert,
  input  logic        req_reverse,
  input  logic        turn_edge,
  output logic        piezo_out,
  output logic [4:0]  grant,
  output logic        active
);

  localparam int PRESC_DIV = CLK_HZ / 1000;
  localparam int PW        = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [15:0]   HOLD_MIN   = 16'(MIN_HOLD_MS);
  localparam logic [15:0]   CLICK_MS   = 16'(TURN_CLICK_MS);
  localparam logic [15:0]   REV_ON     = 16'(REV_ON_MS);
  localparam logic [15:0]   REV_LAST   = 16'(2 * REV_ON_MS - 1);
  localparam logic [18:0]   ENG_BASE19 = 19'(ENG_BASE_HALF);
  localparam logic [18:0]   ENG_MIN19  = 19'(ENG_MIN_HALF);

  arb_state_t    state;
  logic          click_pending;
  logic          click_rearm;   // a turn edge arrived while its click was already sounding
  logic [PW-1:0] presc;
  logic [15:0]   hold_ms;
  logic [15:0]   rev_ms;

  logic          tick;
  logic          click_done;
  logic          regrant;
  logic [4:0]    req_eff;
  logic [4:0]    winner;
  logic [4:0]    grant_nxt;
  logic [15:0]   rev_ms_nxt;
  logic          tone_en;
  logic [18:0]   rpm_x8;
  logic [17:0]   eng_half;
  logic [17:0]   half_sel;

  assign tick = (state == ST_SERVE) && (presc == PRESC_LAST);

  // Engine pitch rises with rpm; widened by one bit so large rpm clamps instead of wrapping
  always_comb begin
    rpm_x8 = {2'b00, rpm, 3'b000};
    if ((rpm_x8 + ENG_MIN19) >= ENG_BASE19) eng_half = ENG_MIN19[17:0];
    else                                    eng_half = 18'(ENG_BASE19 - rpm_x8);
  end

  always_comb begin
    click_done = (state == ST_SERVE) && grant[SRC_CLICK] && (hold_ms >= CLICK_MS);
    // At click completion the click request reflects only clicks still owed after this one
    req_eff = {req_horn, req_alert,
               click_done ? (click_rearm | turn_edge) : click_pending,
               req_reverse & engine_on, engine_on};
    winner = prio_pick(req_eff);
    if (state == ST_IDLE) begin
      regrant = |req_eff;
    end else begin
      regrant = (req_horn && !grant[SRC_HORN])
             || ((grant[SRC_ENG] || grant[SRC_REV]) && !engine_on)
             || click_done
             || ((hold_ms >= HOLD_MIN) && (winner != grant));
    end
    grant_nxt = regrant ? winner : grant;

    rev_ms_nxt = rev_ms;
    if (regrant)   rev_ms_nxt = '0;
    else if (tick) rev_ms_nxt = (rev_ms == REV_LAST) ? 16'd0 : rev_ms + 16'd1;

    // Gate and pitch use next-cycle values so the tone register lines up with the grant
    tone_en = (grant_nxt != 5'd0) && !(grant_nxt[SRC_REV] && (rev_ms_nxt >= REV_ON));

    half_sel = eng_half;
    if (grant_nxt[SRC_HORN])       half_sel = 18'(HORN_HALF);
    else if (grant_nxt[SRC_ALERT]) half_sel = 18'(ALERT_HALF);
    else if (grant_nxt[SRC_CLICK]) half_sel = 18'(CLICK_HALF);
    else if (grant_nxt[SRC_REV])   half_sel = 18'(REV_HALF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      grant         <= '0;
      active        <= 1'b0;
      click_pending <= 1'b0;
      click_rearm   <= 1'b0;
      presc         <= '0;
      hold_ms       <= '0;
      rev_ms        <= '0;
    end else begin
      grant         <= grant_nxt;
      active        <= |grant_nxt;
      state         <= (|grant_nxt) ? ST_SERVE : ST_IDLE;
      click_pending <= turn_edge | (click_done ? click_rearm : click_pending);
      click_rearm   <= click_done ? 1'b0 : (click_rearm | (turn_edge & grant[SRC_CLICK]));
      rev_ms        <= rev_ms_nxt;
      if (regrant) begin
        presc   <= '0;
        hold_ms <= '0;
      end else if (tick) begin
        presc   <= '0;
        hold_ms <= (hold_ms == 16'hFFFF) ? hold_ms : hold_ms + 16'd1;
      end else if (state == ST_SERVE) begin
        presc   <= presc + PW'(1);
      end
    end
  end

  piezo_tone_gen u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (regrant),
    .enable  (tone_en),
    .half    (half_sel),
    .wave    (piezo_out)
  );

endmodule
